cisr_row_dispatch: RTL
======================

// Module: cisr_row_dispatch
// PURPOSE
// - Producer side of the per-channel row-length FIFOs drained by the CISR accumulator.
// - Takes a row-ordered stream of row lengths and pushes each one into the FIFO of the channel that
//   the accumulator will free next. Row k must therefore receive row_id k in the accumulator.
// - The channel choice replays the accumulator's policy with per-channel shadow load counters.
// PARAMETERS
// - channel_num      4   number of CISR channels / row-length FIFOs
// - channel_num_log  2   log2(channel_num), channel index width
// - row_len_size     8   row-length width; matches the accumulator's FIFO data width
// - load_bits        9   shadow load width; must be >= row_len_size+1
// - row_id_size      16  row index / row count width
// PORTS
// - clk                 in   1                       clock; rising edge
// - rst                 in   1                       reset; asynchronous, active-high
// - start               in   1                       pulse; begin a matrix of num_rows rows
// - num_rows            in   row_id_size             rows to dispatch; sampled on start
// - row_len_in          in   row_len_size            incoming row length, row order
// - row_len_valid       in   1                       row_len_in valid
// - row_len_ready       out  1                       dispatcher accepts row_len_in this cycle
// - row_len_fifo_wdata  out  row_len_size*channel_num packed per-channel write data, channel i at [i*row_len_size+:row_len_size]
// - row_len_fifo_write  out  channel_num             one-hot write strobe
// - row_len_fifo_full   in   channel_num             per-channel FIFO full
// - rows_sent           out  row_id_size             rows written this matrix
// - busy                out  1                       state != IDLE and state != DONE
// - done                out  1                       high while in DONE
// BEHAVIOUR
// - Reset: state=IDLE, all loads=0, target=0, len_q=0, rows_sent=0, wdata=0. Outputs low: write, ready, busy, done.
// - FSM states: IDLE, ACCEPT, WRITE, DONE.
// - IDLE/DONE: on start, clear loads and rows_sent and latch num_rows.
//   - num_rows==0: go to DONE.
//   - otherwise: go to ACCEPT.
//   - Without start, the state holds.
// - ACCEPT: row_len_ready=1 (combinational from state).
//   - On row_len_valid: len_q<=row_len_in; target<=argmin(load[]), ties go to the lowest index. Go to WRITE.
// - WRITE: row_len_ready=0.
//   - If row_len_fifo_full[target]: stall in WRITE. No strobe, no state change.
//   - Else (same cycle):
//     - row_len_fifo_write[target]=1, driven combinationally for exactly one cycle.
//     - Data comes from wdata, which is registered as len_q replicated to all lanes.
//     - load[target]+=len_q.
//     - Subtract m from every load, where m = min of the updated loads.
//     - rows_sent+=1.
//     - Go to DONE if the new rows_sent == num_rows, else go to ACCEPT.
// - Throughput: one row per 2 cycles when there is no backpressure. Latency from accept to strobe is 1 cycle.
// - Normalisation invariant:
//   - After each write, min(load)=0 and every load is at most 2^row_len_size-1.
//   - load_bits = row_len_size+1 can never overflow. No wrap logic is needed.
// - Zero-length row: adds 0 to its channel's load, so the next row goes to the same channel if that channel is still the lowest-index minimum. This matches the accumulator's immediate reload.
// - Full flags for non-target channels are ignored. A full on the target never drops or reorders rows.
// - start while busy: ignored.
// - row_len_valid outside ACCEPT: ignored (not consumed).
// - Reset mid-matrix: immediate return to reset state. Any partially written matrix is discarded. The FIFOs are reset externally by the same rst.
// CONFIGURATION
// - CISR_DISPATCH_STATS_EN defined:
//   - Adds output stall_cycles[31:0], which counts cycles spent in WRITE with the target full.
//   - Cleared by rst and by an accepted start. Saturates at 2^32-1.
// - CISR_DISPATCH_STATS_EN undefined: the port and counter are absent. All other behaviour is identical.
// TESTING
// - Channel order, no stalls. Setup: channel_num=4; lengths 3,1,2,5,0,4.
//   - Required strobes to channels 0,1,2,3,1,1.
//   - Final loads {1,3,0,3}; rows_sent=6; done=1.
// - Backpressure. Setup: full[2]=1 for 5 cycles while row 2 targets channel 2.
//   - Required: WRITE held, no strobe, ready=0.
//   - After release: a single strobe on channel 2 carrying len 2.
// - num_rows=0 with start: DONE on the next edge; done=1; no strobes; ready never high.
// - Reset mid-matrix: assert rst after 3 of 6 rows.
//   - Required: all outputs at reset values asynchronously.
//   - A new start then dispatches row 0 to channel 0.
// - Saturation-free: 64 rows of length 255.
//   - Required: round-robin 0,1,2,3,...
//   - No load ever exceeds 255; min(load)=0 after every write.
// - With CISR_DISPATCH_STATS_EN: the test 2 run gives stall_cycles=5. A following start clears it to 0.

Source files
------------

// File: rtl/cisr_row_dispatch.sv
// rtl/cisr_row_dispatch.sv - row-length dispatcher feeding the per-channel CISR row-length FIFOs
//
// Purpose: accepts a row-ordered stream of row lengths and writes each one into the
// FIFO of the channel the accumulator will free next, tracked by shadow load counters.
// Optional feature macro: CISR_DISPATCH_STATS_EN (adds stall_cycles output).
//
// Ports:
//   clk, rst               clock (rising edge), asynchronous active-high reset
//   start, num_rows        begin a matrix of num_rows rows (num_rows sampled on start)
//   row_len_in/_valid      incoming row length stream
//   row_len_ready          dispatcher accepts row_len_in this cycle
//   row_len_fifo_wdata     per-channel write data, channel i at [i*row_len_size +: row_len_size]
//   row_len_fifo_write     one-hot write strobe
//   row_len_fifo_full      per-channel FIFO full flags
//   rows_sent              rows written for the current matrix
//   busy, done             matrix in progress / matrix complete
//   stall_cycles           (CISR_DISPATCH_STATS_EN only) cycles stalled on a full target
module cisr_row_dispatch #(
    parameter int channel_num     = 4,
    parameter int channel_num_log = 2,
    parameter int row_len_size    = 8,
    parameter int load_bits       = 9,
    parameter int row_id_size     = 16
) (
    input  logic                                clk,
    input  logic                                rst,
    input  logic                                start,
    input  logic [row_id_size-1:0]              num_rows,
    input  logic [row_len_size-1:0]             row_len_in,
    input  logic                                row_len_valid,
    output logic                                row_len_ready,
    output logic [row_len_size*channel_num-1:0] row_len_fifo_wdata,
    output logic [channel_num-1:0]              row_len_fifo_write,
    input  logic [channel_num-1:0]              row_len_fifo_full,
    output logic [row_id_size-1:0]              rows_sent,
    output logic                                busy,
    output logic                                done
`ifdef CISR_DISPATCH_STATS_EN
    ,
    output logic [31:0]                         stall_cycles
`endif
);

    typedef enum logic [1:0] {
        IDLE   = 2'd0,
        ACCEPT = 2'd1,
        WRITE  = 2'd2,
        DONE   = 2'd3
    } state_t;

    state_t                              state_q;
    logic [load_bits-1:0]                load_q [channel_num];
    logic [load_bits-1:0]                load_d [channel_num];
    logic [load_bits-1:0]                upd    [channel_num];
    logic [load_bits-1:0]                upd_min;
    logic [channel_num_log-1:0]          target_q;
    logic [channel_num_log-1:0]          min_idx;
    logic [load_bits-1:0]                min_val;
    logic [row_len_size-1:0]             len_q;
    logic [row_id_size-1:0]              rows_sent_q;
    logic [row_id_size-1:0]              rows_sent_d;
    logic [row_id_size-1:0]              num_rows_q;
    logic [row_len_size*channel_num-1:0] wdata_q;
    logic                                target_full;
`ifdef CISR_DISPATCH_STATS_EN
    logic [31:0]                         stall_q;
`endif

    // Channel the accumulator frees next: smallest shadow load, lowest index on ties.
    always_comb begin
        min_idx = '0;
        min_val = load_q[0];
        for (int i = 1; i < channel_num; i++) begin
            if (load_q[i] < min_val) begin
                min_val = load_q[i];
                min_idx = channel_num_log'(i);
            end
        end
    end

    // Add the written row to its channel, then renormalise so the minimum load is zero.
    // With every load bounded by one row length this keeps load_bits = row_len_size+1 wrap-free.
    always_comb begin
        for (int i = 0; i < channel_num; i++) begin
            upd[i] = load_q[i];
            if (target_q == channel_num_log'(i)) begin
                upd[i] = load_q[i] + {{(load_bits-row_len_size){1'b0}}, len_q};
            end
        end
        upd_min = upd[0];
        for (int i = 1; i < channel_num; i++) begin
            if (upd[i] < upd_min) begin
                upd_min = upd[i];
            end
        end
        for (int i = 0; i < channel_num; i++) begin
            load_d[i] = upd[i] - upd_min;
        end
    end

    assign target_full = row_len_fifo_full[target_q];
    assign rows_sent_d = rows_sent_q + row_id_size'(1);

    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            state_q     <= IDLE;
            for (int i = 0; i < channel_num; i++) begin
                load_q[i] <= '0;
            end
            target_q    <= '0;
            len_q       <= '0;
            rows_sent_q <= '0;
            num_rows_q  <= '0;
            wdata_q     <= '0;
`ifdef CISR_DISPATCH_STATS_EN
            stall_q     <= '0;
`endif
        end else begin
            case (state_q)
                IDLE, DONE: begin
                    if (start) begin
                        for (int i = 0; i < channel_num; i++) begin
                            load_q[i] <= '0;
                        end
                        rows_sent_q <= '0;
                        num_rows_q  <= num_rows;
`ifdef CISR_DISPATCH_STATS_EN
                        stall_q     <= '0;
`endif
                        state_q     <= (num_rows == '0) ? DONE : ACCEPT;
                    end
                end
                ACCEPT: begin
                    if (row_len_valid) begin
                        len_q    <= row_len_in;
                        wdata_q  <= {channel_num{row_len_in}};
                        target_q <= min_idx;
                        state_q  <= WRITE;
                    end
                end
                WRITE: begin
                    if (target_full) begin
`ifdef CISR_DISPATCH_STATS_EN
                        if (stall_q != '1) begin
                            stall_q <= stall_q + 32'd1;
                        end
`endif
                    end else begin
                        for (int i = 0; i < channel_num; i++) begin
                            load_q[i] <= load_d[i];
                        end
                        rows_sent_q <= rows_sent_d;
                        state_q     <= (rows_sent_d == num_rows_q) ? DONE : ACCEPT;
                    end
                end
                default: state_q <= IDLE;
            endcase
        end
    end

    // Strobe is combinational so it rises and falls with the WRITE cycle that completes.
    always_comb begin
        row_len_fifo_write = '0;
        if (state_q == WRITE && !target_full) begin
            row_len_fifo_write[target_q] = 1'b1;
        end
    end

    assign row_len_ready      = (state_q == ACCEPT);
    assign row_len_fifo_wdata = wdata_q;
    assign rows_sent          = rows_sent_q;
    assign busy               = (state_q == ACCEPT) || (state_q == WRITE);
    assign done               = (state_q == DONE);
`ifdef CISR_DISPATCH_STATS_EN
    assign stall_cycles       = stall_q;
`endif

endmodule
